// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART transmitter: producers push bytes, a small FSM
// hands the head byte to the transmitter through the uart_tx_en / uart_tx_ack handshake.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  wr_drop,
  output logic [7:0]            uart_tx_data,
  output logic                  uart_tx_en,
  input  logic                  uart_tx_ack
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                  ack_q, ack_rise;
  logic                  push, pop;
  state_t                state, state_nxt;

  assign full     = (count == DEPTH_CNT);
  assign empty    = (count == '0);
  assign ack_rise = uart_tx_ack && !ack_q;

  // A pop is only honoured while the FSM is offering a byte; the ack edge that
  // follows a flush arrives in BUSY and is ignored, so count cannot underflow.
  assign push = wr_en && !full && !flush;
  assign pop  = (state == REQ) && ack_rise && !flush;

  assign uart_tx_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      wr_drop <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      ack_q   <= uart_tx_ack;
      wr_drop <= wr_en && full && !flush;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!flush && !empty && !uart_tx_ack) state_nxt = REQ;
      // A flush while offering a byte still parks in BUSY: the transmitter may
      // have latched on this same edge and must be allowed to finish.
      REQ:  if (flush || ack_rise) state_nxt = BUSY;
      BUSY: if (!flush && !uart_tx_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    uart_tx_en = (state == REQ);
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo: a queue-based FIFO model plus a behavioural
// transmitter that latches on en and holds ack for a fixed byte time.
module tb_uart_tx_fifo;

  localparam int BYTE_CLKS = 40;
  localparam int DEPTH     = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       flush = 1'b0;
  logic       full, empty, wr_drop, uart_tx_en;
  logic [4:0] count;
  logic [7:0] uart_tx_data;
  logic       uart_tx_ack = 1'b0;

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .full(full), .empty(empty), .count(count), .wr_drop(wr_drop),
    .uart_tx_data(uart_tx_data), .uart_tx_en(uart_tx_en), .uart_tx_ack(uart_tx_ack)
  );

  always #5 clk = ~clk;

  int  total = 0;
  int  bad = 0;
  logic [7:0] q[$];     // bytes accepted but not yet latched by the transmitter
  bit  pend = 0;        // byte latched last edge, not yet removed from count
  bit  drop_exp = 0;
  bit  latched = 0;
  int  tx_st = 0;       // 0 idle, 1 sending, 2 cleanup
  int  tx_cnt = 0;
  int  cyc = 0;
  int  fall_cyc = -1;

  function automatic logic [7:0] exp_flags();
    int c;
    c = q.size() + int'(pend);
    return {5'(c), c == 0, c == DEPTH, drop_exp};
  endfunction

  // One clock: drive inputs at the falling edge, advance model and transmitter after the rising edge.
  task automatic step(input logic w, input logic [7:0] d, input logic f);
    logic en_c;
    logic [7:0] data_c;
    bit full_pre;
    wr_en = w; wr_data = d; flush = f;
    en_c = uart_tx_en; data_c = uart_tx_data;
    full_pre = (q.size() + int'(pend)) == DEPTH;
    @(posedge clk); #1;
    cyc++;
    latched = 0; pend = 0; drop_exp = 0;
    case (tx_st)
      0: if (en_c) begin
        total++;
        if (q.size() == 0 || data_c !== q[0]) begin
          bad++;
          $display("FAIL tx_byte got=%h exp=%h", data_c, (q.size() != 0) ? q[0] : 8'hxx);
        end
        if (q.size() != 0) void'(q.pop_front());
        pend = 1; latched = 1; tx_st = 1; tx_cnt = BYTE_CLKS; uart_tx_ack = 1'b1;
      end
      1: begin
        tx_cnt--;
        if (tx_cnt == 0) begin uart_tx_ack = 1'b0; tx_st = 2; fall_cyc = cyc; end
      end
      default: tx_st = 0;
    endcase
    if (f) begin
      q.delete(); pend = 0;
    end else if (w) begin
      if (full_pre) drop_exp = 1;
      else q.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic drain(output bit ok);
    ok = 0;
    for (int i = 0; i < 1500; i++) begin
      if (q.size() == 0 && !pend && tx_st == 0 && !uart_tx_en) begin ok = 1; return; end
      step(1'b0, 8'h00, 1'b0);
    end
  endtask

  task automatic wait_latch(output bit ok);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 8'h00, 1'b0);
      if (latched) begin ok = 1; return; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; #1;
    total++;
    if ({count, empty, full, wr_drop, uart_tx_en} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state got=%b exp=%b", {count, empty, full, wr_drop, uart_tx_en}, 9'b000001000);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    bit saw_en;
    step(1'b1, 8'hA5, 1'b0);
    total++;
    if ({empty, uart_tx_en} !== 2'b00) begin
      bad++; $display("FAIL single_n1 empty,en got=%b exp=00", {empty, uart_tx_en});
    end
    step(1'b0, 8'h00, 1'b0);
    total++;
    if ({uart_tx_en, count} !== {1'b1, 5'd1}) begin
      bad++; $display("FAIL single_n2 en,count got=%b exp=%b", {uart_tx_en, count}, 6'b100001);
    end
    step(1'b0, 8'h00, 1'b0);
    total++;
    if ({latched, count} !== {1'b1, 5'd1}) begin
      bad++; $display("FAIL single_n3 latched,count got=%b exp=%b", {latched, count}, 6'b100001);
    end
    step(1'b0, 8'h00, 1'b0);
    total++;
    if ({uart_tx_en, count, empty} !== {1'b0, 5'd0, 1'b1}) begin
      bad++; $display("FAIL single_n4 en,count,empty got=%b exp=%b", {uart_tx_en, count, empty}, 7'b0000001);
    end
    drain(ok);
    saw_en = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b0);
      saw_en |= uart_tx_en;
    end
    total++;
    if (!ok || saw_en) begin
      bad++; $display("FAIL single_idle drained=%0d en_seen=%0d exp drained=1 en_seen=0", ok, saw_en);
    end
  endtask

  task automatic test_burst();
    bit ok;
    int gap_bad;
    step(1'b1, 8'h55, 1'b0);
    wait_latch(ok);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0);
      total++;
      if ({count, empty, full, wr_drop} !== exp_flags()) begin
        bad++; $display("FAIL burst_push%0d flags got=%b exp=%b", i, {count, empty, full, wr_drop}, exp_flags());
      end
    end
    total++;
    if ({ok, full, count} !== {1'b1, 1'b1, 5'd16}) begin
      bad++; $display("FAIL burst_full ok,full,count got=%b exp=1110000", {ok, full, count});
    end
    step(1'b1, 8'h10, 1'b0);
    total++;
    if ({wr_drop, count} !== {1'b1, 5'd16}) begin
      bad++; $display("FAIL burst_drop drop,count got=%b exp=110000", {wr_drop, count});
    end
    gap_bad = 0; ok = 0;
    for (int i = 0; i < 1500; i++) begin
      step(1'b0, 8'h00, 1'b0);
      if (latched && fall_cyc >= 0 && cyc - fall_cyc > 3) gap_bad++;
      if (q.size() == 0 && !pend && tx_st == 0) begin ok = 1; break; end
    end
    total++;
    if (!ok || gap_bad != 0) begin
      bad++; $display("FAIL burst_drain drained=%0d long_gaps=%0d exp drained=1 long_gaps=0", ok, gap_bad);
    end
  endtask

  task automatic test_wrap();
    bit ok1, ok2;
    for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 1'b0);
    drain(ok1);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 8'($urandom), 1'b0);
      total++;
      if ({count, empty, full, wr_drop} !== exp_flags()) begin
        bad++; $display("FAIL wrap_push%0d flags got=%b exp=%b", i, {count, empty, full, wr_drop}, exp_flags());
      end
    end
    drain(ok2);
    total++;
    if (!(ok1 && ok2)) begin
      bad++; $display("FAIL wrap_drain got=%0d%0d exp=11", ok1, ok2);
    end
  endtask

  task automatic test_simultaneous();
    bit ok1, ok2, ok3;
    step(1'b1, 8'hC1, 1'b0);
    wait_latch(ok1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0);
    wait_latch(ok2);
    total++;
    if ({ok2, count} !== {1'b1, 5'd5}) begin
      bad++; $display("FAIL simul_pre latched,count got=%b exp=100101", {ok2, count});
    end
    step(1'b1, 8'hE7, 1'b0);
    total++;
    if ({count, wr_drop} !== {5'd5, 1'b0}) begin
      bad++; $display("FAIL simul_push_pop count,drop got=%b exp=001010", {count, wr_drop});
    end
    for (int i = 0; i < 11; i++) step(1'b1, 8'($urandom), 1'b0);
    total++;
    if ({ok1, full} !== 2'b11) begin
      bad++; $display("FAIL simul_full ok,full got=%b exp=11", {ok1, full});
    end
    wait_latch(ok3);
    step(1'b1, 8'h99, 1'b0);
    total++;
    if ({ok3, wr_drop, count} !== {1'b1, 1'b1, 5'd15}) begin
      bad++; $display("FAIL simul_full_drop ok,drop,count got=%b exp=1101111", {ok3, wr_drop, count});
    end
    drain(ok1);
    total++;
    if (!ok1) begin bad++; $display("FAIL simul_drain got=0 exp=1"); end
  endtask

  task automatic test_flush();
    bit ok, saw_en, saw_latch;
    step(1'b1, 8'h3C, 1'b0);
    wait_latch(ok);
    for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h77, 1'b1);
    total++;
    if ({ok, count, empty, wr_drop, uart_tx_ack} !== {1'b1, 5'd0, 1'b1, 1'b0, 1'b1}) begin
      bad++; $display("FAIL flush_clear got=%b exp=100000101", {ok, count, empty, wr_drop, uart_tx_ack});
    end
    saw_en = 0; saw_latch = 0;
    for (int i = 0; i < BYTE_CLKS + 10; i++) begin
      step(1'b0, 8'h00, 1'b0);
      saw_en |= uart_tx_en; saw_latch |= latched;
    end
    total++;
    if ({saw_en, saw_latch, uart_tx_ack} !== 3'b000) begin
      bad++; $display("FAIL flush_quiet en,latch,ack got=%b exp=000", {saw_en, saw_latch, uart_tx_ack});
    end
    step(1'b1, 8'h5A, 1'b0);
    wait_latch(ok);
    drain(saw_en);
    total++;
    if (!(ok && saw_en)) begin
      bad++; $display("FAIL flush_after_push got=%0d%0d exp=11", ok, saw_en);
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 99) == 0));
      total++;
      if ({count, empty, full, wr_drop} !== exp_flags()) begin
        bad++; $display("FAIL random_c%0d flags got=%b exp=%b", i, {count, empty, full, wr_drop}, exp_flags());
      end
    end
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL random_drain got=0 exp=1"); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    step(1'b1, 8'h21, 1'b0);
    wait_latch(ok);
    for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), 1'b0);
    step(1'b1, 8'h22, 1'b0);
    wr_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({count, empty, full, wr_drop, uart_tx_en} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_mid got=%b exp=%b", {count, empty, full, wr_drop, uart_tx_en}, 9'b000001000);
    end
    q.delete(); pend = 0; drop_exp = 0; tx_st = 0; uart_tx_ack = 1'b0;
    @(negedge clk); rst = 1'b0;
    step(1'b1, 8'h6B, 1'b0);
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL reset_mid_recover got=0 exp=1"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
